// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    // Expected parity bit for up to 9 data bits (zero-extended); odd=1 selects odd parity.
    function automatic logic parity_of(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous rx pin; idles high out of reset.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with AXI-stream output; parity checking is built
// only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int STOP_BITS      = 1,
    parameter int DIV_WIDTH      = 16,
    parameter int CYCLES_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  cfg_div_valid,
    input  logic                  cfg_parity_odd,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  overflow,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    rx_state_t             state_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  stop_idx_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  ferr_q;
    logic                  perr_q;
    logic                  odd_q;
    logic                  armed_q;
    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  overflow_q;
    logic                  frame_err_q;
    logic                  parity_err_q;

    logic                  rx_s;
    logic [DIV_WIDTH-1:0]  div_sel_s;
    logic [DIV_WIDTH-1:0]  div_eff_s;
    logic [DIV_WIDTH-1:0]  bit_last_s;
    logic [DIV_WIDTH-1:0]  half_last_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // Divisor selection and the bit/half-bit terminal counts (divisor floored at 2).
    always_comb begin
        div_sel_s = DIV_WIDTH'(CYCLES_PER_BIT);
        if (cfg_div_valid) begin
            div_sel_s = cfg_div;
        end else begin
            div_sel_s = DIV_WIDTH'(CYCLES_PER_BIT);
        end
        if (div_q < DIV_WIDTH'(2)) begin
            div_eff_s = DIV_WIDTH'(2);
        end else begin
            div_eff_s = div_q;
        end
        bit_last_s  = div_eff_s - DIV_WIDTH'(1);
        half_last_s = (div_eff_s >> 1) - DIV_WIDTH'(1);
    end

`ifndef UART_RX_PARITY_EN
    logic unused_cfg_s;
    assign unused_cfg_s = cfg_parity_odd;
`endif

    // Receive FSM with registered stream and error-pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_q        <= '0;
            idx_q        <= '0;
            stop_idx_q   <= 1'b0;
            shreg_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            odd_q        <= 1'b0;
            armed_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            if (tvalid_q && tready) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // A start edge only counts once the line has been seen high,
                    // so a held break cannot retrigger frames.
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q    <= 1'b0;
                        state_q    <= START;
                        cnt_q      <= '0;
                        div_q      <= div_sel_s;
`ifdef UART_RX_PARITY_EN
                        odd_q      <= cfg_parity_odd;
`endif
                        ferr_q     <= 1'b0;
                        perr_q     <= 1'b0;
                        stop_idx_q <= 1'b0;
                    end
                end
                START: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end else if (cnt_q == half_last_s) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == bit_last_s) begin
                        cnt_q   <= '0;
                        shreg_q <= {rx_s, shreg_q[DATA_WIDTH-1:1]};
                        if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt_q == bit_last_s) begin
                        cnt_q   <= '0;
                        perr_q  <= (rx_s != parity_of(9'(shreg_q), odd_q));
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
                STOP: begin
                    if (cnt_q == bit_last_s) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            ferr_q <= 1'b1;
                        end
                        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                            state_q <= DONE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                DONE: begin
                    tdata_q      <= shreg_q;
                    tvalid_q     <= 1'b1;
                    overflow_q   <= tvalid_q && !tready;
                    frame_err_q  <= ferr_q;
                    parity_err_q <= perr_q;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tvalid     = tvalid_q;
    assign tdata      = tdata_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule
